// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: raccoon crossing game sequencer with lives, level and score counters, timed by frame ticks
module game_flow_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 30,
    parameter int LEVEL_MAX    = 7,
    parameter int GOAL_Y       = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Start,
    input  logic       i_Frame_Tick,
    input  logic       i_Collision,
    input  logic [9:0] i_Raccoon_Y,
    output logic [2:0] o_State,
    output logic       o_Move_En,
    output logic       o_Respawn,
    output logic [2:0] o_Lives,
    output logic [2:0] o_Level,
    output logic [9:0] o_Score
);
    typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, DEATH = 3'd2, WIN = 3'd3, GAME_OVER = 3'd4} state_t;
    state_t     state;
    logic       start_q;
    logic       start_rise;
    logic       dead_out;
    logic [7:0] timer;
    assign start_rise = i_Start & ~start_q;
    assign dead_out   = (state == DEATH) && (o_Lives == 3'd0);
    assign o_State    = state;
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= IDLE;
            start_q   <= 1'b1;
            timer     <= 8'd0;
            o_Move_En <= 1'b0;
            o_Respawn <= 1'b0;
            o_Lives   <= 3'd0;
            o_Level   <= 3'd0;
            o_Score   <= 10'd0;
        end else begin
            start_q   <= i_Start;
            o_Respawn <= 1'b0;
            o_Move_En <= 1'b0;
            case (state)
                IDLE, GAME_OVER: if (start_rise) begin
                    state     <= PLAY;
                    o_Lives   <= 3'(LIVES_INIT);
                    o_Level   <= 3'd0;
                    o_Score   <= 10'd0;
                    o_Respawn <= 1'b1;
                end
                PLAY: if (!o_Respawn && i_Collision) begin
                    state   <= DEATH;
                    o_Lives <= o_Lives - {2'b0, |o_Lives};
                    timer   <= 8'(DEATH_FRAMES);
                end else if (!o_Respawn && i_Raccoon_Y == 10'(GOAL_Y)) begin
                    state   <= WIN;
                    o_Score <= o_Score + {9'd0, ~&o_Score};
                    timer   <= 8'(WIN_FRAMES);
                end else begin
                    o_Move_En <= 1'b1;
                end
                DEATH, WIN: if (i_Frame_Tick) begin
                    if (timer <= 8'd1) begin
                        timer     <= 8'd0;
                        state     <= dead_out ? GAME_OVER : PLAY;
                        o_Respawn <= !dead_out;
                        if (state == WIN)
                            o_Level <= (o_Level >= 3'(LEVEL_MAX)) ? 3'(LEVEL_MAX) : o_Level + 3'd1;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the raccoon crossing game. It runs the state machine IDLE -> PLAY -> DEATH/WIN -> GAME_OVER and keeps the lives, level and score counters. It gates raccoon movement and issues a one-cycle respawn pulse that reloads the raccoon start position. It sits between the raccoon position/collision logic and the VGA frame timing, and is timed by frame ticks rather than a free-running clock divider.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..7)
DEATH_FRAMES, 60, frame ticks spent in DEATH (1..255)
WIN_FRAMES, 30, frame ticks spent in WIN (1..255)
LEVEL_MAX, 7, level saturation value (0..7)
GOAL_Y, 0, raccoon Y value that counts as reaching the goal row

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Start  in  1  start button, level; only its rising edge is used
i_Frame_Tick  in  1  one-cycle pulse per video frame
i_Collision  in  1  raccoon/obstacle overlap, level
i_Raccoon_Y  in  10  current raccoon Y position
o_State  out  3  0=IDLE 1=PLAY 2=DEATH 3=WIN 4=GAME_OVER
o_Move_En  out  1  raccoon movement enable
o_Respawn  out  1  one-cycle pulse: reload raccoon start position
o_Lives  out  3  remaining lives
o_Level  out  3  current level (obstacle speed select)
o_Score  out  10  goals reached, saturating

Behaviour:
- Reset: async and active-low, allowed at any time including mid-game.
  - Values under reset: o_State=IDLE, o_Move_En=0, o_Respawn=0, o_Lives=0, o_Level=0, o_Score=0, timer=0.
  - Start edge register = 1, so a button held through reset does not start a game.
- Start edge: start_rise = i_Start & ~start_q; start_q samples i_Start every cycle. start_rise is acted on only in IDLE and GAME_OVER and ignored in every other state.
- All outputs are registered. o_Move_En = (state==PLAY) & ~o_Respawn.
- IDLE, on start_rise -> PLAY:
  - Load lives=LIVES_INIT, level=0, score=0.
  - o_Respawn=1 in the first PLAY cycle.
- PLAY:
  - The respawn cycle ignores i_Collision and the goal check, because position is stale that cycle.
  - Otherwise, if i_Collision=1 -> DEATH; lives decrements (lives>=1 is guaranteed here) and the timer is loaded with DEATH_FRAMES.
  - Else, if i_Raccoon_Y==GOAL_Y -> WIN; score increments, saturating at 1023, and the timer is loaded with WIN_FRAMES.
  - Collision has priority over goal when both occur in the same cycle.
- DEATH / WIN timer:
  - Decrements on each i_Frame_Tick sampled while in the state. A tick in the entry cycle is not counted.
  - When the timer is 1 and a tick is sampled, the state exits on the next edge. Dwell is therefore exactly DEATH_FRAMES or WIN_FRAMES ticks.
- DEATH exit:
  - lives==0 -> GAME_OVER.
  - Otherwise -> PLAY with a respawn pulse.
- WIN exit:
  - level = (level==LEVEL_MAX) ? LEVEL_MAX : level+1.
  - -> PLAY with a respawn pulse.
- GAME_OVER:
  - o_Move_En=0. o_Lives, o_Level and o_Score hold so the final result stays displayed.
  - On start_rise -> PLAY with the same initialisation as from IDLE, plus a respawn pulse.
- o_Respawn is high for exactly one cycle, coincident with the first cycle o_State==PLAY after any entry into PLAY. It never occurs in any other state.
- Illegal state encodings (5..7) -> IDLE on the next edge.
- Timer is 8 bits; lives and level are 3 bits; score is 10 bits. No counter may wrap.

Test Plan (LIVES_INIT=3, DEATH_FRAMES=4, WIN_FRAMES=2, LEVEL_MAX=2):
- Reset held with i_Start=1, then release; i_Start stays 1 -> state remains IDLE. Drop then raise i_Start -> PLAY, Respawn high exactly 1 cycle, Lives=3, Move_En=1 from the next cycle.
- In PLAY, assert i_Collision and goal (i_Raccoon_Y=0) in the same cycle -> DEATH, Lives=2, Score=0. Give 4 ticks -> PLAY with Respawn; 3 ticks -> still DEATH. A tick on the entry cycle is not counted.
- Three collisions, each followed by 4 ticks -> Lives 2,1,0, then GAME_OVER with Move_En=0 and Score/Level held. Start edge -> PLAY, Lives=3, Score=0, Level=0.
- Three goals with 2 ticks each -> Score=3, Level 1,2,2 (saturates). Collision asserted during the respawn cycle -> ignored, state stays PLAY.
- Pulse i_Start while in PLAY, DEATH and WIN -> no effect. Assert reset mid-DEATH -> all outputs go to reset values immediately, without a clock edge.
